// File: rtl/pc_pkg.sv
// Shared opcode definitions for the program-counter sequencer.
package pc_pkg;

  localparam int unsigned OPCODE_W = 3;

  typedef enum logic [OPCODE_W-1:0] {
    OP_HOLD   = 3'b000,
    OP_INC    = 3'b001,
    OP_JMP    = 3'b010,
    OP_BRR    = 3'b011,
    OP_CALL   = 3'b100,
    OP_RET    = 3'b101,
    OP_RST    = 3'b110,
    OP_CLRERR = 3'b111
  } opcode_e;

endpackage

// File: rtl/pc_ret_stack.sv
// LIFO return-address stack. Callers guarantee push/pop are never
// requested when full/empty respectively; entries above count are stale.
module pc_ret_stack
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           clr_i,
  input  logic                           push_i,
  input  logic                           pop_i,
  input  logic [ADDR_W-1:0]              push_data_i,
  output logic [ADDR_W-1:0]              top_data_o,
  output logic [$clog2(STACK_DEPTH):0]   count_o
);

  localparam int unsigned IDX_W = $clog2(STACK_DEPTH);
  localparam int unsigned SP_W  = IDX_W + 1;

  logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
  logic [SP_W-1:0]   count_q;
  logic [SP_W-1:0]   count_d;
  logic [SP_W-1:0]   top_idx;

  assign top_idx    = count_q - SP_W'(1);
  assign top_data_o = mem_q[top_idx[IDX_W-1:0]];
  assign count_o    = count_q;

  // Occupancy update: clear wins, otherwise one push or one pop.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (push_i) begin
      count_d = count_q + SP_W'(1);
    end else if (pop_i) begin
      count_d = count_q - SP_W'(1);
    end
  end

  // Occupancy register; contents are deliberately not reset.
  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Entry storage: a push writes the slot just above the current top.
  always_ff @(negedge clk_i) begin
    if (push_i && !clr_i) begin
      mem_q[count_q[IDX_W-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer with call/return stack and sticky
// overflow/underflow flags. All state advances on the falling clock edge.
module pc_seq_unit
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 16,
  parameter int unsigned       STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
  input  logic                          I_CLK,
  input  logic                          I_RST,
  input  logic                          I_EN,
  input  logic [OPCODE_W-1:0]           I_OPCODE,
  input  logic [ADDR_W-1:0]             I_PC,
  input  logic [ADDR_W-1:0]             I_OFFSET,
  output logic [ADDR_W-1:0]             O_PC,
  output logic [$clog2(STACK_DEPTH):0]  O_SP,
  output logic                          O_FULL,
  output logic                          O_EMPTY,
  output logic                          O_OVF,
  output logic                          O_UNF
);

  localparam int unsigned SP_W = $clog2(STACK_DEPTH) + 1;

  opcode_e           op;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              push, pop, clr;
  logic [ADDR_W-1:0] ret_addr;
  logic [ADDR_W-1:0] top_data;
  logic [SP_W-1:0]   sp;
  logic              full, empty;

  assign op       = opcode_e'(I_OPCODE);
  assign ret_addr = pc_q + ADDR_W'(1);
  assign full     = (sp == SP_W'(STACK_DEPTH));
  assign empty    = (sp == '0);

  pc_ret_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk_i       (I_CLK),
    .rst_i       (I_RST),
    .clr_i       (clr),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (ret_addr),
    .top_data_o  (top_data),
    .count_o     (sp)
  );

  // Opcode decode: next PC, stack requests and error flags.
  always_comb begin
    pc_d  = pc_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    pop   = 1'b0;
    clr   = 1'b0;
    if (I_EN) begin
      case (op)
        OP_INC: pc_d = pc_q + ADDR_W'(1);
        OP_JMP: pc_d = I_PC;
        OP_BRR: pc_d = pc_q + I_OFFSET;
        OP_CALL: begin
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            push = 1'b1;
            pc_d = I_PC;
          end
        end
        OP_RET: begin
          if (empty) begin
            unf_d = 1'b1;
          end else begin
            pop  = 1'b1;
            pc_d = top_data;
          end
        end
        OP_RST: begin
          pc_d  = RESET_VEC;
          ovf_d = 1'b0;
          unf_d = 1'b0;
          clr   = 1'b1;
        end
        OP_CLRERR: begin
          ovf_d = 1'b0;
          unf_d = 1'b0;
        end
        default: pc_d = pc_q;
      endcase
    end
  end

  // PC and sticky flag registers.
  always_ff @(negedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      pc_q  <= RESET_VEC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign O_PC    = pc_q;
  assign O_SP    = sp;
  assign O_FULL  = full;
  assign O_EMPTY = empty;
  assign O_OVF   = ovf_q;
  assign O_UNF   = unf_q;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed bench for pc_seq_unit (RESET_VEC = 0x0100, depth 8).
module tb_pc_seq_unit;
  import pc_pkg::*;

  logic        clk;
  logic        rst;
  logic        en;
  logic [2:0]  opcode;
  logic [15:0] pc_in;
  logic [15:0] off;
  logic [15:0] o_pc;
  logic [3:0]  o_sp;
  logic        o_full, o_empty, o_ovf, o_unf;

  int errors = 0;
  int checks = 0;

  pc_seq_unit #(
    .ADDR_W      (16),
    .STACK_DEPTH (8),
    .RESET_VEC   (16'h0100)
  ) dut (
    .I_CLK    (clk),
    .I_RST    (rst),
    .I_EN     (en),
    .I_OPCODE (opcode),
    .I_PC     (pc_in),
    .I_OFFSET (off),
    .O_PC     (o_pc),
    .O_SP     (o_sp),
    .O_FULL   (o_full),
    .O_EMPTY  (o_empty),
    .O_OVF    (o_ovf),
    .O_UNF    (o_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Drive one operation before a falling edge, then settle after it.
  task automatic step(input logic e, input logic [2:0] op,
                      input logic [15:0] p, input logic [15:0] o);
    @(posedge clk);
    en = e; opcode = op; pc_in = p; off = o;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #1;
    checks++; if (o_pc !== 16'h0100) begin errors++; $display("FAIL rst_pc: got %h expected %h", o_pc, 16'h0100); end
    checks++; if (o_sp !== 4'd0) begin errors++; $display("FAIL rst_sp: got %0d expected %0d", o_sp, 0); end
    checks++; if ({o_ovf, o_unf, o_full, o_empty} !== 4'b0001) begin errors++; $display("FAIL rst_flags: got %b expected %b", {o_ovf, o_unf, o_full, o_empty}, 4'b0001); end
    @(posedge clk);
    rst = 1'b0;
  endtask

  task automatic test_inc_stall;
    logic [15:0] exp_pc;
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, OP_INC, 16'h0, 16'h0);
      exp_pc = 16'h0100 + 16'(i);
      checks++; if (o_pc !== exp_pc) begin errors++; $display("FAIL inc_pc%0d: got %h expected %h", i, o_pc, exp_pc); end
    end
    step(1'b0, OP_INC, 16'h0, 16'h0);
    checks++; if (o_pc !== 16'h0103) begin errors++; $display("FAIL stall_inc: got %h expected %h", o_pc, 16'h0103); end
    step(1'b0, OP_RST, 16'h0, 16'h0);
    checks++; if (o_pc !== 16'h0103) begin errors++; $display("FAIL stall_rst: got %h expected %h", o_pc, 16'h0103); end
  endtask

  task automatic test_wrap;
    step(1'b1, OP_JMP, 16'hFFFF, 16'h0);
    checks++; if (o_pc !== 16'hFFFF) begin errors++; $display("FAIL jmp_ffff: got %h expected %h", o_pc, 16'hFFFF); end
    step(1'b1, OP_INC, 16'h0, 16'h0);
    checks++; if (o_pc !== 16'h0000) begin errors++; $display("FAIL inc_wrap: got %h expected %h", o_pc, 16'h0000); end
    step(1'b1, OP_JMP, 16'h0005, 16'h0);
    step(1'b1, OP_BRR, 16'h0, 16'hFFF8);
    checks++; if (o_pc !== 16'hFFFD) begin errors++; $display("FAIL brr_back: got %h expected %h", o_pc, 16'hFFFD); end
    step(1'b1, OP_BRR, 16'h0, 16'h0010);
    checks++; if (o_pc !== 16'h000D) begin errors++; $display("FAIL brr_fwd: got %h expected %h", o_pc, 16'h000D); end
    step(1'b1, OP_HOLD, 16'h1234, 16'h0);
    checks++; if (o_pc !== 16'h000D) begin errors++; $display("FAIL hold: got %h expected %h", o_pc, 16'h000D); end
  endtask

  task automatic test_nested;
    step(1'b1, OP_JMP, 16'h0010, 16'h0);
    step(1'b1, OP_CALL, 16'h0200, 16'h0);
    checks++; if (o_pc !== 16'h0200) begin errors++; $display("FAIL call1_pc: got %h expected %h", o_pc, 16'h0200); end
    checks++; if (o_sp !== 4'd1) begin errors++; $display("FAIL call1_sp: got %0d expected %0d", o_sp, 1); end
    step(1'b1, OP_CALL, 16'h0300, 16'h0);
    checks++; if (o_sp !== 4'd2) begin errors++; $display("FAIL call2_sp: got %0d expected %0d", o_sp, 2); end
    checks++; if (o_pc !== 16'h0300) begin errors++; $display("FAIL call2_pc: got %h expected %h", o_pc, 16'h0300); end
    step(1'b1, OP_RET, 16'h0, 16'h0);
    checks++; if (o_pc !== 16'h0201) begin errors++; $display("FAIL ret1_pc: got %h expected %h", o_pc, 16'h0201); end
    step(1'b1, OP_RET, 16'h0, 16'h0);
    checks++; if (o_pc !== 16'h0011) begin errors++; $display("FAIL ret2_pc: got %h expected %h", o_pc, 16'h0011); end
    checks++; if ({o_empty, o_sp} !== {1'b1, 4'd0}) begin errors++; $display("FAIL ret2_empty: got %b/%0d expected 1/0", o_empty, o_sp); end
  endtask

  task automatic test_overflow;
    step(1'b1, OP_RST, 16'h0, 16'h0);
    for (int i = 0; i < 8; i++) step(1'b1, OP_CALL, 16'h1000 + 16'(i * 16), 16'h0);
    checks++; if (o_pc !== 16'h1070) begin errors++; $display("FAIL fill_pc: got %h expected %h", o_pc, 16'h1070); end
    checks++; if ({o_full, o_ovf, o_sp} !== {1'b1, 1'b0, 4'd8}) begin errors++; $display("FAIL fill_state: got full=%b ovf=%b sp=%0d expected 1 0 8", o_full, o_ovf, o_sp); end
    step(1'b1, OP_CALL, 16'h2000, 16'h0);
    checks++; if (o_pc !== 16'h1070) begin errors++; $display("FAIL ovf_pc: got %h expected %h", o_pc, 16'h1070); end
    checks++; if ({o_full, o_ovf, o_sp} !== {1'b1, 1'b1, 4'd8}) begin errors++; $display("FAIL ovf_state: got full=%b ovf=%b sp=%0d expected 1 1 8", o_full, o_ovf, o_sp); end
    step(1'b0, OP_CLRERR, 16'h0, 16'h0);
    checks++; if (o_ovf !== 1'b1) begin errors++; $display("FAIL stall_clrerr: got %b expected %b", o_ovf, 1'b1); end
    step(1'b1, OP_CLRERR, 16'h0, 16'h0);
    checks++; if ({o_ovf, o_sp} !== {1'b0, 4'd8}) begin errors++; $display("FAIL clrerr_ovf: got ovf=%b sp=%0d expected 0 8", o_ovf, o_sp); end
    step(1'b1, OP_RET, 16'h0, 16'h0);
    checks++; if (o_pc !== 16'h1061) begin errors++; $display("FAIL full_ret_pc: got %h expected %h", o_pc, 16'h1061); end
    checks++; if ({o_full, o_sp} !== {1'b0, 4'd7}) begin errors++; $display("FAIL full_ret_sp: got full=%b sp=%0d expected 0 7", o_full, o_sp); end
  endtask

  task automatic test_underflow;
    step(1'b1, OP_RST, 16'h0, 16'h0);
    checks++; if ({o_pc, o_sp, o_empty} !== {16'h0100, 4'd0, 1'b1}) begin errors++; $display("FAIL rstop: got pc=%h sp=%0d empty=%b expected 0100 0 1", o_pc, o_sp, o_empty); end
    step(1'b1, OP_RET, 16'h0, 16'h0);
    checks++; if ({o_pc, o_sp, o_unf} !== {16'h0100, 4'd0, 1'b1}) begin errors++; $display("FAIL unf_ret: got pc=%h sp=%0d unf=%b expected 0100 0 1", o_pc, o_sp, o_unf); end
    step(1'b1, OP_INC, 16'h0, 16'h0);
    step(1'b1, OP_INC, 16'h0, 16'h0);
    checks++; if ({o_pc, o_unf} !== {16'h0102, 1'b1}) begin errors++; $display("FAIL unf_sticky: got pc=%h unf=%b expected 0102 1", o_pc, o_unf); end
    step(1'b1, OP_RST, 16'h0, 16'h0);
    checks++; if ({o_pc, o_unf} !== {16'h0100, 1'b0}) begin errors++; $display("FAIL unf_rstop: got pc=%h unf=%b expected 0100 0", o_pc, o_unf); end
    step(1'b1, OP_RET, 16'h0, 16'h0);
    step(1'b1, OP_CLRERR, 16'h0, 16'h0);
    checks++; if ({o_pc, o_unf} !== {16'h0100, 1'b0}) begin errors++; $display("FAIL unf_clrerr: got pc=%h unf=%b expected 0100 0", o_pc, o_unf); end
  endtask

  task automatic test_async_reset;
    step(1'b1, OP_CALL, 16'h0400, 16'h0);
    step(1'b1, OP_CALL, 16'h0410, 16'h0);
    step(1'b1, OP_CALL, 16'h0456, 16'h0);
    checks++; if ({o_pc, o_sp} !== {16'h0456, 4'd3}) begin errors++; $display("FAIL pre_arst: got pc=%h sp=%0d expected 0456 3", o_pc, o_sp); end
    @(posedge clk);
    en = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if ({o_pc, o_sp} !== {16'h0100, 4'd0}) begin errors++; $display("FAIL arst: got pc=%h sp=%0d expected 0100 0", o_pc, o_sp); end
    @(posedge clk);
    rst = 1'b0;
    step(1'b1, OP_INC, 16'h0, 16'h0);
    checks++; if (o_pc !== 16'h0101) begin errors++; $display("FAIL post_arst_inc: got %h expected %h", o_pc, 16'h0101); end
    step(1'b1, OP_RET, 16'h0, 16'h0);
    checks++; if ({o_pc, o_unf} !== {16'h0101, 1'b1}) begin errors++; $display("FAIL post_arst_ret: got pc=%h unf=%b expected 0101 1", o_pc, o_unf); end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; opcode = 3'b000; pc_in = '0; off = '0;
    test_reset();
    test_inc_stall();
    test_wrap();
    test_nested();
    test_overflow();
    test_underflow();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
